stereo_calc_scheduler: RTL and testbench

//  Sequences the left/right calc buffers (WIN_W x WIN_H window per camera) for disparity matching.

---
 rtl/stereo_calc_scheduler_pkg.sv | 24 ++
 rtl/stereo_calc_scheduler_if.sv | 36 +++
 rtl/stereo_calc_scheduler_cam_frame_tracker.sv | 49 ++++
 rtl/stereo_calc_scheduler.sv | 170 +++++++++++++++++
 tb/tb_stereo_calc_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/stereo_calc_scheduler_pkg.sv
// Shared types and window defaults for the stereo calc-buffer scheduler.
// The window defaults must stay in step with the cam2ram window constants.
package stereo_pkg;
   localparam int DEF_WIN_W = 79;
   localparam int DEF_WIN_H = 16;
   localparam int X_W       = 7;
   localparam int Y_W       = 4;
   localparam int PIX_W     = 3;
   localparam int CNT_W     = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      CAPT   = 2'd1,
      FROZEN = 2'd2
   } trk_state_t;
endpackage

// File: rtl/stereo_calc_scheduler_if.sv
// Bundles the capture gates, calc-RAM read port and matcher stream of the scheduler.
interface stereo_calc_scheduler_if #(
   parameter int ADDR_W = 11
);
   logic                        enable;
   logic                        left_vsync;
   logic                        right_vsync;
   logic                        cap_en_left;
   logic                        cap_en_right;
   logic [ADDR_W-1:0]           rdaddr_calc;
   logic                        match_ready;
   logic [stereo_pkg::PIX_W-1:0] q_left;
   logic [stereo_pkg::PIX_W-1:0] q_right;
   logic                        pix_valid;
   logic [stereo_pkg::PIX_W-1:0] pix_left;
   logic [stereo_pkg::PIX_W-1:0] pix_right;
   logic [stereo_pkg::X_W-1:0]   pix_x;
   logic [stereo_pkg::Y_W-1:0]   pix_y;
   logic                        pix_last;
   logic                        frame_done;
   logic [stereo_pkg::CNT_W-1:0] frame_cnt;
   logic                        skew_err;
   logic                        busy;

   modport slave (
      input  enable, left_vsync, right_vsync, match_ready, q_left, q_right,
      output cap_en_left, cap_en_right, rdaddr_calc, pix_valid, pix_left, pix_right,
             pix_x, pix_y, pix_last, frame_done, frame_cnt, skew_err, busy
   );

   modport master (
      output enable, left_vsync, right_vsync, match_ready, q_left, q_right,
      input  cap_en_left, cap_en_right, rdaddr_calc, pix_valid, pix_left, pix_right,
             pix_x, pix_y, pix_last, frame_done, frame_cnt, skew_err, busy
   );
endinterface

// File: rtl/stereo_calc_scheduler_cam_frame_tracker.sv
// Per-camera capture gate: synchronises raw vsync and opens the calc-buffer write
// window for exactly one vsync-to-vsync frame, then freezes it.
module cam_frame_tracker
   import stereo_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_vsync,
   input  logic i_hold_off,
   output logic o_cap_en,
   output logic o_frozen
);
   logic [2:0] r_sync;
   logic       r_cap_en;
   logic       w_edge;
   trk_state_t r_state;
   trk_state_t w_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync   <= 3'b000;
         r_state  <= OFF;
         r_cap_en <= 1'b0;
      end else begin
         r_sync   <= {r_sync[1:0], i_vsync};
         r_state  <= w_next;
         r_cap_en <= (w_next == CAPT);
      end
   end

   // r_sync[1] is the synchronised level, r_sync[2] its previous value
   always_comb begin
      w_edge = r_sync[1] & ~r_sync[2];
      w_next = r_state;
      if (i_hold_off) begin
         w_next = OFF;
      end else begin
         case (r_state)
            OFF:     w_next = w_edge ? CAPT : OFF;
            CAPT:    w_next = w_edge ? FROZEN : CAPT;
            FROZEN:  w_next = FROZEN;
            default: w_next = OFF;
         endcase
      end
   end

   assign o_cap_en = r_cap_en;
   assign o_frozen = (r_state == FROZEN);
endmodule

// File: rtl/stereo_calc_scheduler.sv
// Stereo calc-buffer scheduler: gates one clean frame into each calc buffer, then
// reads both in lockstep and streams delay-matched pixel pairs to the matcher.
module stereo_calc_scheduler
   import stereo_pkg::*;
#(
   parameter int WIN_W        = DEF_WIN_W,
   parameter int WIN_H        = DEF_WIN_H,
   parameter int ADDR_W       = 11,
   parameter int RD_LAT       = 2,
   parameter int SKEW_TIMEOUT = 1000000,
   parameter int TO_W         = 24
)(
   input logic                    i_sysclk,
   input logic                    i_rst,
   stereo_calc_scheduler_if.slave bus
);
   localparam logic [X_W-1:0]  X_LAST  = X_W'(WIN_W - 1);
   localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(WIN_H - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(SKEW_TIMEOUT - 1);

   sched_state_t      r_state;
   sched_state_t      w_next;
   logic              w_issue, w_fire, w_hold_off, w_is_last;
   logic              w_cap_l, w_cap_r, w_frozen_l, w_frozen_r;
   logic [TO_W-1:0]   r_timer;
   logic [ADDR_W-1:0] r_addr;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [RD_LAT-1:0] r_pv, r_pl;
   logic [X_W-1:0]    r_px [RD_LAT];
   logic [Y_W-1:0]    r_py [RD_LAT];
   logic              r_pix_valid, r_pix_last, r_frame_done, r_skew_err, r_busy;
   logic [PIX_W-1:0]  r_pix_left, r_pix_right;
   logic [X_W-1:0]    r_pix_x;
   logic [Y_W-1:0]    r_pix_y;
   logic [CNT_W-1:0]  r_frame_cnt;

   cam_frame_tracker u_trk_left (
      .i_clk(i_sysclk), .i_rst(i_rst), .i_vsync(bus.left_vsync),
      .i_hold_off(w_hold_off), .o_cap_en(w_cap_l), .o_frozen(w_frozen_l)
   );

   cam_frame_tracker u_trk_right (
      .i_clk(i_sysclk), .i_rst(i_rst), .i_vsync(bus.right_vsync),
      .i_hold_off(w_hold_off), .o_cap_en(w_cap_r), .o_frozen(w_frozen_r)
   );

   assign w_is_last = (r_x == X_LAST) && (r_y == Y_LAST);

   always_comb begin
      w_next     = r_state;
      w_issue    = 1'b0;
      w_fire     = 1'b0;
      w_hold_off = 1'b0;
      case (r_state)
         IDLE: begin
            w_hold_off = 1'b1;
            w_next     = bus.enable ? ARM : IDLE;
         end
         ARM: begin
            if (w_frozen_l && w_frozen_r) begin
               w_next = READ;
            end else if ((w_frozen_l ^ w_frozen_r) && (r_timer == TO_LAST)) begin
               w_fire     = 1'b1;
               w_hold_off = 1'b1;
            end else begin
               w_next = ARM;
            end
         end
         READ: begin
            w_issue = bus.match_ready;
            w_next  = (bus.match_ready && w_is_last) ? DRAIN : READ;
         end
         DRAIN: w_next = (r_pv == {RD_LAT{1'b0}}) ? DONE : DRAIN;
         DONE: begin
            w_hold_off = 1'b1;
            w_next     = bus.enable ? ARM : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Skew timer only runs while exactly one camera has frozen
   always_ff @(posedge i_sysclk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_timer <= {TO_W{1'b0}};
         r_addr  <= {ADDR_W{1'b0}};
         r_x     <= {X_W{1'b0}};
         r_y     <= {Y_W{1'b0}};
      end else begin
         r_state <= w_next;
         if ((r_state == ARM) && (w_frozen_l ^ w_frozen_r) && !w_fire) begin
            r_timer <= r_timer + TO_W'(1);
         end else begin
            r_timer <= {TO_W{1'b0}};
         end
         if ((r_state == ARM) && (w_next == READ)) begin
            r_addr <= {ADDR_W{1'b0}};
            r_x    <= {X_W{1'b0}};
            r_y    <= {Y_W{1'b0}};
         end else if (w_issue && !w_is_last) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_x == X_LAST) begin
               r_x <= {X_W{1'b0}};
               r_y <= r_y + Y_W'(1);
            end else begin
               r_x <= r_x + X_W'(1);
            end
         end
      end
   end

   // Issue pipe matches the RAM latency; the output stage registers q
   always_ff @(posedge i_sysclk or posedge i_rst) begin
      if (i_rst) begin
         r_pv         <= {RD_LAT{1'b0}};
         r_pl         <= {RD_LAT{1'b0}};
         for (int i = 0; i < RD_LAT; i++) begin
            r_px[i] <= {X_W{1'b0}};
            r_py[i] <= {Y_W{1'b0}};
         end
         r_pix_valid  <= 1'b0;
         r_pix_last   <= 1'b0;
         r_pix_left   <= {PIX_W{1'b0}};
         r_pix_right  <= {PIX_W{1'b0}};
         r_pix_x      <= {X_W{1'b0}};
         r_pix_y      <= {Y_W{1'b0}};
         r_frame_done <= 1'b0;
         r_frame_cnt  <= {CNT_W{1'b0}};
         r_skew_err   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_pv[0] <= w_issue;
         r_pl[0] <= w_issue & w_is_last;
         r_px[0] <= r_x;
         r_py[0] <= r_y;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pl[i] <= r_pl[i-1];
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
         end
         r_pix_valid  <= r_pv[RD_LAT-1];
         r_pix_last   <= r_pl[RD_LAT-1];
         r_pix_x      <= r_px[RD_LAT-1];
         r_pix_y      <= r_py[RD_LAT-1];
         r_pix_left   <= bus.q_left;
         r_pix_right  <= bus.q_right;
         r_frame_done <= (w_next == DONE);
         r_frame_cnt  <= (w_next == DONE) ? r_frame_cnt + CNT_W'(1) : r_frame_cnt;
         r_skew_err   <= w_fire;
         r_busy       <= (w_next != IDLE);
      end
   end

   assign bus.cap_en_left  = w_cap_l;
   assign bus.cap_en_right = w_cap_r;
   assign bus.rdaddr_calc  = r_addr;
   assign bus.pix_valid    = r_pix_valid;
   assign bus.pix_left     = r_pix_left;
   assign bus.pix_right    = r_pix_right;
   assign bus.pix_x        = r_pix_x;
   assign bus.pix_y        = r_pix_y;
   assign bus.pix_last     = r_pix_last;
   assign bus.frame_done   = r_frame_done;
   assign bus.frame_cnt    = r_frame_cnt;
   assign bus.skew_err     = r_skew_err;
   assign bus.busy         = r_busy;
endmodule

// File: tb/tb_stereo_calc_scheduler.sv
// Directed bench: a scenario table of stereo frames plus hand-written timeout and
// mid-read reset sequences, scored against hand-derived expectations.
module tb_stereo_calc_scheduler;
   import stereo_pkg::*;

   localparam int P      = 300;
   localparam int TMO    = 600;
   localparam int NPIX   = 79 * 16;
   localparam int BUDGET = 6000;

   typedef struct {
      int   skew;
      bit   toggle;
      bit   drop;
      bit   extra;
      int   exp_fall_diff;
      int   exp_gap;
      int   exp_pix;
      logic exp_busy;
   } scn_t;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [2:0] r_ml = 3'd0;
   logic [2:0] r_mr = 3'd0;
   int         checks  = 0;
   int         errors  = 0;
   int         exp_cnt = 0;
   scn_t       tbl [5];

   stereo_calc_scheduler_if #(.ADDR_W(11)) bus ();

   stereo_calc_scheduler #(.SKEW_TIMEOUT(TMO)) dut (
      .i_sysclk(clk),
      .i_rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Calc RAM models with two-cycle read latency, contents addr[2:0] / ~addr[2:0]
   always @(posedge clk) begin
      r_ml        <= bus.rdaddr_calc[2:0];
      r_mr        <= ~bus.rdaddr_calc[2:0];
      bus.q_left  <= r_ml;
      bus.q_right <= r_mr;
   end

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic bit pulse(input int t, input int s);
      return (t >= s) && (t < s + 4);
   endfunction

   function automatic logic [42:0] outs();
      return {bus.cap_en_left, bus.cap_en_right, bus.rdaddr_calc, bus.pix_valid,
              bus.pix_left, bus.pix_right, bus.pix_x, bus.pix_y, bus.pix_last,
              bus.frame_done, bus.frame_cnt, bus.skew_err, bus.busy};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_scn(input scn_t s);
      int rl = -1, fl = -1, rr = -1, fr = -1, nl = 0, nr = 0, nskew = 0, nb = 0;
      int npix = 0, last_s = -1, done_s = -1, prev_v = -1, gmin = BUDGET, gmax = 0;
      logic pcl = 1'b0, pcr = 1'b0;
      logic [17:0] exp_p, act_p;
      bus.enable = 1'b1;
      for (int t = 0; t < BUDGET && done_s < 0; t++) begin
         step();
         bus.left_vsync  = pulse(t, 4) || pulse(t, 4 + P) ||
                           (s.extra && pulse(t, 4 + P + s.skew + 100));
         bus.right_vsync = pulse(t, 4 + s.skew) || pulse(t, 4 + s.skew + P);
         bus.match_ready = s.toggle ? t[0] : 1'b1;
         if (s.drop && t == 4 + P + 50) bus.enable = 1'b0;
         @(negedge clk);
         if (bus.cap_en_left && !pcl) begin nl++; rl = t; end
         if (!bus.cap_en_left && pcl) fl = t;
         if (bus.cap_en_right && !pcr) begin nr++; rr = t; end
         if (!bus.cap_en_right && pcr) fr = t;
         pcl = bus.cap_en_left;
         pcr = bus.cap_en_right;
         if (bus.skew_err) nskew++;
         if (bus.pix_valid) begin
            exp_p = {7'(npix % 79), 4'(npix / 79), 3'(npix), ~3'(npix), npix == NPIX - 1};
            act_p = {bus.pix_x, bus.pix_y, bus.pix_left, bus.pix_right, bus.pix_last};
            chk("pixel", act_p, exp_p);
            if (prev_v >= 0) begin
               if (t - prev_v < gmin) gmin = t - prev_v;
               if (t - prev_v > gmax) gmax = t - prev_v;
            end
            prev_v = t;
            npix++;
         end
         if (bus.pix_last) last_s = t;
         if (bus.frame_done) begin
            done_s = t;
            exp_cnt++;
            chk("frame_cnt", bus.frame_cnt, exp_cnt % 256);
         end
      end
      chk("frame_done_seen", done_s >= 0, 1);
      chk("cap_l_rise", rl, 7);
      chk("cap_r_rise", rr, 7 + s.skew);
      chk("cap_l_len", fl - rl, P);
      chk("cap_r_len", fr - rr, P);
      chk("fall_skew", fr - fl, s.exp_fall_diff);
      chk("cap_l_rises", nl, 1);
      chk("cap_r_rises", nr, 1);
      chk("pix_count", npix, s.exp_pix);
      chk("gap_min", gmin, s.exp_gap);
      chk("gap_max", gmax, s.exp_gap);
      chk("last_to_done", done_s - last_s, 1);
      chk("no_skew_err", nskew, 0);
      bus.left_vsync  = 1'b0;
      bus.right_vsync = 1'b0;
      step();
      @(negedge clk);
      chk("done_pulse_width", bus.frame_done, 0);
      repeat (3) step();
      @(negedge clk);
      chk("busy_after", bus.busy, s.exp_busy);
      if (!s.exp_busy) begin
         for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (bus.busy) nb++;
         end
         chk("stay_idle", nb, 0);
      end
   endtask

   initial begin
      int fl, sk, nr, rl, hit;
      logic pcl;
      tbl[0] = '{0,   1'b0, 1'b0, 1'b0, 0,   1, NPIX, 1'b1};
      tbl[1] = '{500, 1'b0, 1'b0, 1'b1, 500, 1, NPIX, 1'b1};
      tbl[2] = '{0,   1'b1, 1'b0, 1'b0, 0,   2, NPIX, 1'b1};
      tbl[3] = '{200, 1'b0, 1'b1, 1'b0, 200, 1, NPIX, 1'b0};
      tbl[4] = '{0,   1'b0, 1'b0, 1'b0, 0,   1, NPIX, 1'b1};
      bus.enable      = 1'b0;
      bus.left_vsync  = 1'b0;
      bus.right_vsync = 1'b0;
      bus.match_ready = 1'b0;

      repeat (3) step();
      @(negedge clk);
      chk("reset_outputs", outs(), 0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_scn(tbl[i]);

      // Right camera silent: left freeze must time out and release the trackers
      bus.enable = 1'b1;
      fl = -1; sk = -1; nr = 0; pcl = 1'b0;
      for (int t = 0; t < 2000 && sk < 0; t++) begin
         step();
         bus.left_vsync  = pulse(t, 4) || pulse(t, 4 + P);
         bus.right_vsync = 1'b0;
         bus.match_ready = 1'b1;
         @(negedge clk);
         if (!bus.cap_en_left && pcl) fl = t;
         pcl = bus.cap_en_left;
         if (bus.cap_en_right) nr++;
         if (bus.skew_err) sk = t;
      end
      chk("skew_err_seen", sk >= 0, 1);
      chk("skew_delay", sk - fl, TMO);
      chk("skew_cap_r", nr, 0);
      bus.left_vsync = 1'b0;
      step();
      @(negedge clk);
      chk("skew_pulse_width", bus.skew_err, 0);
      chk("skew_cap_l_off", bus.cap_en_left, 0);
      chk("skew_busy", bus.busy, 1);
      rl = -1;
      for (int t = 0; t < 10; t++) begin
         step();
         bus.left_vsync = pulse(t, 0);
         @(negedge clk);
         if (bus.cap_en_left && rl < 0) rl = t;
      end
      chk("rearm_rise", rl, 3);

      // Reset in the middle of the read-out
      step();
      rst = 1'b1;
      bus.left_vsync = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      exp_cnt = 0;
      hit = 0;
      for (int t = 0; t < BUDGET && hit == 0; t++) begin
         step();
         bus.left_vsync  = pulse(t, 4) || pulse(t, 4 + P);
         bus.right_vsync = pulse(t, 4) || pulse(t, 4 + P);
         bus.match_ready = 1'b1;
         @(negedge clk);
         if (bus.rdaddr_calc == 11'd600) hit = 1;
      end
      chk("reach_addr600", hit, 1);
      step();
      rst = 1'b1;
      bus.left_vsync  = 1'b0;
      bus.right_vsync = 1'b0;
      @(negedge clk);
      chk("rst_mid_read_outputs", outs(), 0);
      step();
      rst = 1'b0;
      run_scn(tbl[4]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
